rmw_sequencer: RTL and testbench

- Initiator-side controller for the combinational ALU. Sequences the 6502 read-modify-write memory instructions: ASL, LSR, ROL, ROR, INC, DEC.
- Flow per operation: read the operand from memory, drive the ALU, perform the 6502 dummy write of the original value, write the modified value, then hand N/Z/C updates to the status register.
- Sits between the instruction decoder, the memory bus interface and the ALU.

---
 rtl/rmw_sequencer.sv | 152 +++++++++++++++
 tb/tb_rmw_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_sequencer.sv
// rmw_sequencer: sequences the 6502 read-modify-write memory instructions
// (ASL, LSR, ROL, ROR, INC, DEC). It reads the operand, drives the external
// combinational ALU, performs the dummy write of the original value, and then
// writes the modified value while handing N/Z/C updates to the status register.
module rmw_sequencer #(
  parameter int         ADDR_W   = 16,
  parameter logic [4:0] MODE_ADD = 5'd0,
  parameter logic [4:0] MODE_SUB = 5'd1,
  parameter logic [4:0] MODE_SR  = 5'd5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rdy,
  input  logic              c_flag,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [4:0]        alu_mode,
  output logic              alu_carry_in,
  input  logic [7:0]        alu_result,
  input  logic              alu_carry,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              nz_we,
  output logic              c_we,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] OP_ASL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_DEC = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    DUMMY_WR = 2'd2,
    FINAL_WR = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              c_in_q;
  logic [7:0]        operand_q;
  logic [7:0]        result_q;
  logic              n_q, z_q, c_q;
  logic              start_ok;
  logic              is_shift;

  // Ops 6 and 7 are not instructions; a start carrying them is dropped.
  assign start_ok = start && (op < 3'd6);
  // Shifts and rotates occupy op codes 0..3, so bit 2 clear marks them.
  assign is_shift = ~op_q[2];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: only READ can stall (on rdy); the two write cycles never do.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_ok) state_next = READ;
      READ:     if (rdy)      state_next = DUMMY_WR;
      DUMMY_WR: state_next = FINAL_WR;
      FINAL_WR: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request capture, operand latch, and result/flag latch on the dummy-write edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      c_in_q    <= 1'b0;
      operand_q <= '0;
      result_q  <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      if (state == IDLE && start_ok) begin
        op_q   <= op;
        addr_q <= addr;
        c_in_q <= c_flag;
      end
      if (state == READ && rdy) operand_q <= mem_din;
      if (state == DUMMY_WR) begin
        result_q <= alu_result;
        n_q      <= alu_result[7];
        // Z is taken from the 8-bit result; the ALU's own zero test covers the carry too.
        z_q      <= (alu_result == 8'h00);
        if (is_shift) c_q <= alu_carry;
      end
    end
  end

  // ALU operand/mode selection from the latched operand and captured carry.
  always_comb begin
    alu_a        = operand_q;
    alu_b        = 8'h00;
    alu_mode     = MODE_ADD;
    alu_carry_in = 1'b0;
    case (op_q)
      OP_ASL: begin alu_mode = MODE_ADD; alu_b = operand_q; alu_carry_in = 1'b0;   end
      OP_ROL: begin alu_mode = MODE_ADD; alu_b = operand_q; alu_carry_in = c_in_q; end
      OP_LSR: begin alu_mode = MODE_SR;  alu_b = 8'h00;     alu_carry_in = 1'b0;   end
      OP_ROR: begin alu_mode = MODE_SR;  alu_b = 8'h00;     alu_carry_in = c_in_q; end
      OP_INC: begin alu_mode = MODE_ADD; alu_b = 8'h01;     alu_carry_in = 1'b0;   end
      OP_DEC: begin alu_mode = MODE_SUB; alu_b = 8'h01;     alu_carry_in = 1'b1;   end
      default: begin alu_mode = MODE_ADD; alu_b = 8'h00;    alu_carry_in = 1'b0;   end
    endcase
  end

  // Write data: original value on the dummy write, modified value on the final write.
  always_comb begin
    mem_dout = 8'h00;
    case (state)
      DUMMY_WR: mem_dout = operand_q;
      FINAL_WR: mem_dout = result_q;
      default:  mem_dout = 8'h00;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_rd   = (state == READ);
  assign mem_wr   = (state == DUMMY_WR) || (state == FINAL_WR);
  assign nz_we    = (state == FINAL_WR);
  assign c_we     = (state == FINAL_WR) && is_shift;
  assign done     = (state == FINAL_WR);
  assign busy     = (state != IDLE);
  assign flag_n   = n_q;
  assign flag_z   = z_q;
  assign flag_c   = c_q;

endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: self-checking bench for rmw_sequencer with a behavioural
// ALU, a table of directed vectors, hand-written corner sequences and a
// randomized run checked against an arithmetic model of the six instructions.
module tb_rmw_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] addr;
  logic        rdy;
  logic        c_flag;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  alu_a, alu_b;
  logic [4:0]  alu_mode;
  logic        alu_carry_in;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        flag_n, flag_z, flag_c;
  logic        nz_we, c_we, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic model_c = 1'b0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic       cin;
    logic [7:0] res;
    logic       n, z, c, cwe;
  } vec_t;

  vec_t vecs[8];

  rmw_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr),
    .rdy(rdy), .c_flag(c_flag), .mem_din(mem_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .alu_carry(alu_carry), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .nz_we(nz_we), .c_we(c_we), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add, subtract (a + ~b + cin) and right shift.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (alu_mode)
      5'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      5'd1:    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_carry_in};
      5'd5:    alu_sum = {alu_a[0], alu_carry_in, alu_a[7:1]};
      default: alu_sum = 9'h000;
    endcase
  end
  assign alu_result = alu_sum[7:0];
  assign alu_carry  = alu_sum[8];

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Instruction semantics computed arithmetically, independent of ALU modes.
  function automatic void model_op(input logic [2:0] m_op, input logic [7:0] v,
                                   input logic cin, input logic prev_c,
                                   output logic [7:0] res, output logic n,
                                   output logic z, output logic c,
                                   output logic cwe);
    int vi;
    int r;
    vi  = int'(v);
    r   = 0;
    c   = prev_c;
    cwe = 1'b1;
    case (m_op)
      3'd0: begin r = (vi * 2) % 256;              c = (vi >= 128); end
      3'd1: begin r = vi / 2;                      c = (vi % 2 == 1); end
      3'd2: begin r = (vi * 2 + int'(cin)) % 256;  c = (vi >= 128); end
      3'd3: begin r = vi / 2 + 128 * int'(cin);    c = (vi % 2 == 1); end
      3'd4: begin r = (vi + 1) % 256;              cwe = 1'b0; end
      default: begin r = (vi + 255) % 256;         cwe = 1'b0; end
    endcase
    res = 8'(r);
    n   = (r >= 128);
    z   = (r == 0);
  endfunction

  // Runs one full operation from an IDLE cycle and checks every cycle of it.
  task automatic apply_stimulus(input logic [2:0] t_op, input logic [15:0] t_addr,
                                input logic [7:0] t_din, input logic t_cin,
                                input int stalls, input bit glitch,
                                input logic [7:0] e_res, input logic e_n,
                                input logic e_z, input logic e_c, input logic e_cwe);
    start   = 1'b1;
    op      = t_op;
    addr    = t_addr;
    c_flag  = t_cin;
    mem_din = t_din;
    @(posedge clk); #1;
    start  = 1'b0;
    op     = 3'($urandom);
    addr   = 16'($urandom);
    c_flag = 1'($urandom);
    check_output("read_rd",   32'(mem_rd), 32'd1);
    check_output("read_wr",   32'(mem_wr), 32'd0);
    check_output("read_addr", 32'(mem_addr), 32'(t_addr));
    check_output("read_busy", 32'(busy), 32'd1);
    check_output("read_done", 32'(done), 32'd0);
    rdy     = (stalls == 0);
    mem_din = (stalls == 0) ? t_din : ~t_din;
    for (int k = 1; k <= stalls; k++) begin
      if (glitch && k == 1) begin
        start = 1'b1;
        op    = 3'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_output("stall_rd",   32'(mem_rd), 32'd1);
      check_output("stall_addr", 32'(mem_addr), 32'(t_addr));
      check_output("stall_done", 32'(done), 32'd0);
      rdy     = (k == stalls);
      mem_din = (k == stalls) ? t_din : ~t_din;
    end
    @(posedge clk); #1;
    check_output("dummy_wr",   32'(mem_wr), 32'd1);
    check_output("dummy_rd",   32'(mem_rd), 32'd0);
    check_output("dummy_dout", 32'(mem_dout), 32'(t_din));
    check_output("dummy_addr", 32'(mem_addr), 32'(t_addr));
    check_output("dummy_done", 32'(done), 32'd0);
    check_output("dummy_nzwe", 32'(nz_we), 32'd0);
    mem_din = 8'($urandom);
    rdy     = 1'($urandom);
    @(posedge clk); #1;
    check_output("final_wr",   32'(mem_wr), 32'd1);
    check_output("final_rd",   32'(mem_rd), 32'd0);
    check_output("final_dout", 32'(mem_dout), 32'(e_res));
    check_output("final_addr", 32'(mem_addr), 32'(t_addr));
    check_output("final_done", 32'(done), 32'd1);
    check_output("final_nzwe", 32'(nz_we), 32'd1);
    check_output("final_cwe",  32'(c_we), 32'(e_cwe));
    check_output("flag_n",     32'(flag_n), 32'(e_n));
    check_output("flag_z",     32'(flag_z), 32'(e_z));
    check_output("flag_c",     32'(flag_c), 32'(e_c));
    // A start alongside done must be dropped.
    start = 1'b1;
    op    = 3'd1;
    rdy   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_done", 32'(done), 32'd0);
    check_output("idle_wr",   32'(mem_wr), 32'd0);
    check_output("idle_rd",   32'(mem_rd), 32'd0);
  endtask

  initial begin
    logic [7:0] r_res;
    logic       r_n, r_z, r_c, r_cwe;
    logic [2:0] r_op;
    logic [7:0] r_din;
    logic       r_cin;

    vecs[0] = '{op: 3'd0, din: 8'h81, cin: 1'b0, res: 8'h02, n: 1'b0, z: 1'b0, c: 1'b1, cwe: 1'b1};
    vecs[1] = '{op: 3'd0, din: 8'h80, cin: 1'b0, res: 8'h00, n: 1'b0, z: 1'b1, c: 1'b1, cwe: 1'b1};
    vecs[2] = '{op: 3'd3, din: 8'h01, cin: 1'b1, res: 8'h80, n: 1'b1, z: 1'b0, c: 1'b1, cwe: 1'b1};
    vecs[3] = '{op: 3'd1, din: 8'h01, cin: 1'b1, res: 8'h00, n: 1'b0, z: 1'b1, c: 1'b1, cwe: 1'b1};
    vecs[4] = '{op: 3'd4, din: 8'hFF, cin: 1'b0, res: 8'h00, n: 1'b0, z: 1'b1, c: 1'b1, cwe: 1'b0};
    vecs[5] = '{op: 3'd5, din: 8'h00, cin: 1'b0, res: 8'hFF, n: 1'b1, z: 1'b0, c: 1'b1, cwe: 1'b0};
    vecs[6] = '{op: 3'd2, din: 8'h40, cin: 1'b1, res: 8'h81, n: 1'b1, z: 1'b0, c: 1'b0, cwe: 1'b1};
    vecs[7] = '{op: 3'd4, din: 8'h7F, cin: 1'b1, res: 8'h80, n: 1'b1, z: 1'b0, c: 1'b0, cwe: 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    addr    = 16'h0000;
    rdy     = 1'b1;
    c_flag  = 1'b0;
    mem_din = 8'h00;
    #3;
    check_output("rst_busy",  32'(busy), 32'd0);
    check_output("rst_done",  32'(done), 32'd0);
    check_output("rst_rd",    32'(mem_rd), 32'd0);
    check_output("rst_wr",    32'(mem_wr), 32'd0);
    check_output("rst_addr",  32'(mem_addr), 32'd0);
    check_output("rst_dout",  32'(mem_dout), 32'd0);
    check_output("rst_flags", 32'({flag_n, flag_z, flag_c, nz_we, c_we}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].op, 16'h1000 + 16'(i), vecs[i].din, vecs[i].cin, 0, 1'b0,
                     vecs[i].res, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].cwe);
    end
    model_c = vecs[7].c;

    // rdy stall of three cycles with an ignored start pulse mid-stall.
    apply_stimulus(3'd3, 16'hBEEF, 8'h01, 1'b1, 3, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    model_c = 1'b1;

    // Illegal ops must not start anything.
    start = 1'b1;
    op    = 3'd6;
    addr  = 16'h2222;
    @(posedge clk); #1;
    check_output("illegal6_busy", 32'(busy), 32'd0);
    check_output("illegal6_rd",   32'(mem_rd), 32'd0);
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("illegal7_busy", 32'(busy), 32'd0);
    check_output("illegal7_done", 32'(done), 32'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      r_op  = 3'($urandom_range(0, 5));
      r_din = 8'($urandom);
      r_cin = 1'($urandom);
      model_op(r_op, r_din, r_cin, model_c, r_res, r_n, r_z, r_c, r_cwe);
      apply_stimulus(r_op, 16'($urandom), r_din, r_cin, $urandom_range(0, 2), 1'b0,
                     r_res, r_n, r_z, r_c, r_cwe);
      model_c = r_c;
    end

    // Reset during the dummy write aborts the operation.
    start  = 1'b1;
    op     = 3'd0;
    addr   = 16'h5A5A;
    c_flag = 1'b0;
    mem_din = 8'h81;
    rdy    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_output("abort_pre_wr", 32'(mem_wr), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("abort_wr",    32'(mem_wr), 32'd0);
    check_output("abort_busy",  32'(busy), 32'd0);
    check_output("abort_addr",  32'(mem_addr), 32'd0);
    check_output("abort_dout",  32'(mem_dout), 32'd0);
    check_output("abort_flags", 32'({flag_n, flag_z, flag_c, nz_we, c_we, done}), 32'd0);
    @(posedge clk); #1;
    check_output("abort_hold_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("abort_after", 32'({mem_wr, mem_rd, nz_we, c_we, done, busy}), 32'd0);
    end
    model_c = 1'b0;
    check_output("abort_flag_c", 32'(flag_c), 32'(model_c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
